// File: rtl/syzygy_adc_align_seq.sv
// Bring-up and frame-alignment sequencer for SYZYGY LTC226x ADC front ends.
// Optional build macro ADC_ALIGN_LOCK_LOSS_EN: MMCM lock loss after WAIT_LOCK restarts the sequence.
//
// state     | meaning
// WAIT_LOCK | waiting for synced MMCM lock, IDELAYCTRL held in reset
// WAIT_IDLY | waiting for synced IDELAYCTRL ready
// HOLD      | ISERDES reset held for SERDES_HOLD_CYCLES
// SETTLE    | waiting SETTLE_CYCLES after enable/bitslip before comparing
// CHECK     | one-cycle frame compare; slip on mismatch
// LOCKED    | aligned, monitoring for consecutive frame misses
// FAIL      | every sweep exhausted, align_err set until realign
module syzygy_adc_align_seq #(
    parameter int                 NUM_CH             = 2,
    parameter int                 FRAME_W            = 8,
    parameter logic [FRAME_W-1:0] FRAME_PATTERN      = 8'hF0,
    parameter int                 SERDES_HOLD_CYCLES = 64,
    parameter int                 SETTLE_CYCLES      = 4,
    parameter int                 MAX_RETRIES        = 2,
    parameter int                 MISS_LIMIT         = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       mmcm_locked,
    input  logic                       idelay_rdy,
    input  logic [FRAME_W-1:0]         frame_word,
    input  logic                       realign,
    output logic                       reset_idelay,
    output logic                       reset_serdes,
    output logic [NUM_CH-1:0]          ena,
    output logic                       bitslip,
    output logic [$clog2(FRAME_W)-1:0] bitslip_count,
    output logic                       data_valid,
    output logic                       align_err
);

    localparam int BC_W     = $clog2(FRAME_W);
    localparam int SLIP_W   = $clog2(FRAME_W + 1);
    localparam int RETRY_W  = $clog2(MAX_RETRIES + 1);
    localparam int MISS_W   = $clog2(MISS_LIMIT + 1);
    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_WAIT_LOCK, S_WAIT_IDLY, S_HOLD, S_SETTLE, S_CHECK, S_LOCKED, S_FAIL
    } state_t;

    state_t               state;
    logic [7:0]           hold_cnt;
    logic [SETTLE_W-1:0]  settle_cnt;
    logic [SLIP_W-1:0]    slip_cnt;
    logic [RETRY_W-1:0]   retries;
    logic [MISS_W-1:0]    miss_cnt;
    logic                 lock_meta, lock_s, rdy_meta, rdy_s;
    logic                 lock_lost;
    logic                 frame_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
            rdy_meta  <= 1'b0;
            rdy_s     <= 1'b0;
        end else begin
            lock_meta <= mmcm_locked;
            lock_s    <= lock_meta;
            rdy_meta  <= idelay_rdy;
            rdy_s     <= rdy_meta;
        end
    end

    always_comb begin
        frame_ok = (frame_word == FRAME_PATTERN);
`ifdef ADC_ALIGN_LOCK_LOSS_EN
        lock_lost = (state != S_WAIT_LOCK) && !lock_s;
`else
        lock_lost = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_WAIT_LOCK;
            reset_idelay  <= 1'b1;
            reset_serdes  <= 1'b1;
            ena           <= '0;
            bitslip       <= 1'b0;
            bitslip_count <= '0;
            data_valid    <= 1'b0;
            align_err     <= 1'b0;
            hold_cnt      <= '0;
            settle_cnt    <= '0;
            slip_cnt      <= '0;
            retries       <= '0;
            miss_cnt      <= '0;
        end else if (lock_lost) begin
            state         <= S_WAIT_LOCK;
            reset_idelay  <= 1'b1;
            reset_serdes  <= 1'b1;
            ena           <= '0;
            bitslip       <= 1'b0;
            bitslip_count <= '0;
            data_valid    <= 1'b0;
            align_err     <= 1'b0;
            hold_cnt      <= '0;
            settle_cnt    <= '0;
            slip_cnt      <= '0;
            retries       <= '0;
            miss_cnt      <= '0;
        end else begin
            bitslip <= 1'b0;
            case (state)
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        reset_idelay <= 1'b0;
                        state        <= S_WAIT_IDLY;
                    end
                end
                S_WAIT_IDLY: begin
                    if (rdy_s) begin
                        hold_cnt <= 8'(SERDES_HOLD_CYCLES);
                        state    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    hold_cnt <= hold_cnt - 8'd1;
                    if (hold_cnt == 8'd1) begin
                        reset_serdes <= 1'b0;
                        ena          <= '1;
                        settle_cnt   <= SETTLE_W'(SETTLE_CYCLES);
                        state        <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == SETTLE_W'(1)) begin
                        state <= S_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - SETTLE_W'(1);
                    end
                end
                S_CHECK: begin
                    if (frame_ok) begin
                        data_valid <= 1'b1;
                        miss_cnt   <= '0;
                        state      <= S_LOCKED;
                    end else begin
                        bitslip       <= 1'b1;
                        bitslip_count <= (bitslip_count == BC_W'(FRAME_W - 1)) ?
                                         '0 : bitslip_count + BC_W'(1);
                        settle_cnt    <= SETTLE_W'(SETTLE_CYCLES);
                        state         <= S_SETTLE;
                        if (slip_cnt == SLIP_W'(FRAME_W - 1)) begin
                            slip_cnt <= '0;
                            retries  <= retries + RETRY_W'(1);
                            // the slip that completes the last sweep still fires, then we give up
                            if (retries == RETRY_W'(MAX_RETRIES - 1)) begin
                                align_err <= 1'b1;
                                state     <= S_FAIL;
                            end
                        end else begin
                            slip_cnt <= slip_cnt + SLIP_W'(1);
                        end
                    end
                end
                S_LOCKED: begin
                    if (realign) begin
                        data_valid <= 1'b0;
                        retries    <= '0;
                        slip_cnt   <= '0;
                        miss_cnt   <= '0;
                        settle_cnt <= SETTLE_W'(SETTLE_CYCLES);
                        state      <= S_SETTLE;
                    end else if (frame_ok) begin
                        miss_cnt <= '0;
                    end else if (miss_cnt == MISS_W'(MISS_LIMIT - 1)) begin
                        data_valid <= 1'b0;
                        retries    <= '0;
                        slip_cnt   <= '0;
                        miss_cnt   <= '0;
                        settle_cnt <= SETTLE_W'(SETTLE_CYCLES);
                        state      <= S_SETTLE;
                    end else begin
                        miss_cnt <= miss_cnt + MISS_W'(1);
                    end
                end
                S_FAIL: begin
                    data_valid <= 1'b0;
                    if (realign) begin
                        align_err  <= 1'b0;
                        retries    <= '0;
                        slip_cnt   <= '0;
                        miss_cnt   <= '0;
                        settle_cnt <= SETTLE_W'(SETTLE_CYCLES);
                        state      <= S_SETTLE;
                    end
                end
                default: state <= S_WAIT_LOCK;
            endcase
        end
    end

endmodule

// File: tb/tb_syzygy_adc_align_seq.sv
// Directed bench for syzygy_adc_align_seq: bring-up, slip search, miss tolerance, FAIL/realign, reset, wrap.
// Frame lane model: frame_word shows the pattern only when the bench's own slip count equals target_slips.
module tb_syzygy_adc_align_seq;

    logic       clk = 1'b0;
    logic       reset_n, mmcm_locked, idelay_rdy, realign;
    logic [7:0] frame_word;
    logic       reset_idelay, reset_serdes, bitslip, data_valid, align_err;
    logic [1:0] ena;
    logic [2:0] bitslip_count;

    int         n_checks = 0;
    int         n_errors = 0;
    int         slip_pulses = 0;
    int         target_slips = 3;
    int         back_to_back = 0;
    logic       prev_bitslip = 1'b0;
    logic       fw_fixed_en = 1'b0;
    logic [7:0] fw_fixed = 8'h00;

    always #5 clk = ~clk;

    syzygy_adc_align_seq dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .mmcm_locked   (mmcm_locked),
        .idelay_rdy    (idelay_rdy),
        .frame_word    (frame_word),
        .realign       (realign),
        .reset_idelay  (reset_idelay),
        .reset_serdes  (reset_serdes),
        .ena           (ena),
        .bitslip       (bitslip),
        .bitslip_count (bitslip_count),
        .data_valid    (data_valid),
        .align_err     (align_err)
    );

    assign frame_word = fw_fixed_en ? fw_fixed :
                        ((slip_pulses == target_slips) ? 8'hF0 : 8'h3C);

    always @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slip_pulses  = 0;
            prev_bitslip = 1'b0;
        end else begin
            if (bitslip && prev_bitslip) back_to_back++;
            if (bitslip) slip_pulses++;
            prev_bitslip = bitslip;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_val({pfx, "_reset_idelay"},  32'(reset_idelay),  32'd1);
        check_val({pfx, "_reset_serdes"},  32'(reset_serdes),  32'd1);
        check_val({pfx, "_ena"},           32'(ena),           32'd0);
        check_val({pfx, "_bitslip"},       32'(bitslip),       32'd0);
        check_val({pfx, "_bitslip_count"}, 32'(bitslip_count), 32'd0);
        check_val({pfx, "_data_valid"},    32'(data_valid),    32'd0);
        check_val({pfx, "_align_err"},     32'(align_err),     32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        int dv_low;

        reset_n     = 1'b0;
        mmcm_locked = 1'b0;
        idelay_rdy  = 1'b0;
        realign     = 1'b0;
        repeat (3) tick();
        check_reset_outputs("por");

        // nominal bring-up: lock at 10, rdy at 30, pattern after 3 slips
        reset_n = 1'b1;
        repeat (10) tick();
        mmcm_locked = 1'b1;
        repeat (5) tick();
        check_val("idelay_released", 32'(reset_idelay), 32'd0);
        check_val("serdes_still_held", 32'(reset_serdes), 32'd1);
        repeat (15) tick();
        idelay_rdy = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (reset_serdes && n < 200);
        // 2 sync edges + 1 to enter HOLD + 64 hold cycles
        check_val("serdes_hold_cycles", 32'(n), 32'd67);
        check_val("ena_on", 32'(ena), 32'd3);
        n = 0;
        while (!data_valid && n < 500) begin
            tick();
            n++;
        end
        check_val("nominal_dv", 32'(data_valid), 32'd1);
        check_val("nominal_slips", 32'(slip_pulses), 32'd3);
        check_val("nominal_count", 32'(bitslip_count), 32'd3);
        check_val("nominal_err", 32'(align_err), 32'd0);

        // glitch: 3 misses then a match keeps data_valid
        dv_low = 0;
        fw_fixed = 8'h00;
        fw_fixed_en = 1'b1;
        repeat (3) begin
            tick();
            if (!data_valid) dv_low++;
        end
        fw_fixed_en = 1'b0;
        repeat (6) begin
            tick();
            if (!data_valid) dv_low++;
        end
        check_val("glitch_dv_held", 32'(dv_low), 32'd0);

        // 4 consecutive misses drop data_valid, slip comes SETTLE_CYCLES+1 later
        fw_fixed_en = 1'b1;
        n = 0;
        while (data_valid && n < 20) begin
            tick();
            n++;
        end
        check_val("miss_limit_cycles", 32'(n), 32'd4);
        target_slips = 5;
        fw_fixed_en = 1'b0;
        n = 0;
        while (!bitslip && n < 20) begin
            tick();
            n++;
        end
        check_val("realign_slip_delay", 32'(n), 32'd5);
        n = 0;
        while (!data_valid && n < 200) begin
            tick();
            n++;
        end
        check_val("relock_dv", 32'(data_valid), 32'd1);
        check_val("relock_count", 32'(bitslip_count), 32'd5);

        // realign into a lane that never matches: 16 slips then FAIL
        base = slip_pulses;
        fw_fixed = 8'h00;
        fw_fixed_en = 1'b1;
        realign = 1'b1;
        tick();
        realign = 1'b0;
        n = 0;
        while (!align_err && n < 400) begin
            tick();
            n++;
        end
        check_val("fail_err", 32'(align_err), 32'd1);
        check_val("fail_slips", 32'(slip_pulses - base), 32'd16);
        check_val("fail_dv", 32'(data_valid), 32'd0);
        check_val("fail_count", 32'(bitslip_count), 32'd5);
        check_val("fail_ena", 32'(ena), 32'd3);
        base = slip_pulses;
        repeat (10) tick();
        check_val("fail_no_slip", 32'(slip_pulses - base), 32'd0);
        check_val("fail_err_sticky", 32'(align_err), 32'd1);

        // realign from FAIL clears the error and restarts the sweep
        realign = 1'b1;
        tick();
        realign = 1'b0;
        check_val("realign_clr_err", 32'(align_err), 32'd0);
        n = 0;
        while (!bitslip && n < 20) begin
            tick();
            n++;
        end
        check_val("restart_slip_delay", 32'(n), 32'd5);

        // reset asserted while in SETTLE
        reset_n = 1'b0;
        fw_fixed_en = 1'b0;
        target_slips = 8;
        #1;
        check_reset_outputs("async");
        repeat (2) tick();
        reset_n = 1'b1;

        // restart from WAIT_LOCK; pattern first appears at position 0 of the second sweep
        n = 0;
        while (reset_serdes && n < 300) begin
            tick();
            n++;
        end
        check_val("restart_idelay", 32'(reset_idelay), 32'd0);
        check_val("restart_serdes", 32'(reset_serdes), 32'd0);
        n = 0;
        while (!data_valid && n < 500) begin
            tick();
            n++;
        end
        check_val("wrap_dv", 32'(data_valid), 32'd1);
        check_val("wrap_slips", 32'(slip_pulses), 32'd8);
        check_val("wrap_count", 32'(bitslip_count), 32'd0);

`ifdef ADC_ALIGN_LOCK_LOSS_EN
        mmcm_locked = 1'b0;
        n = 0;
        while (!reset_idelay && n < 10) begin
            tick();
            n++;
        end
        check_val("lockloss_cycles", 32'(n), 32'd3);
        check_val("lockloss_serdes", 32'(reset_serdes), 32'd1);
        check_val("lockloss_ena", 32'(ena), 32'd0);
        check_val("lockloss_dv", 32'(data_valid), 32'd0);
`else
        mmcm_locked = 1'b0;
        dv_low = 0;
        repeat (10) begin
            tick();
            if (!data_valid) dv_low++;
        end
        check_val("lockloss_ignored_dv", 32'(dv_low), 32'd0);
        check_val("lockloss_ignored_serdes", 32'(reset_serdes), 32'd0);
`endif

        check_val("no_back_to_back_slip", 32'(back_to_back), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
